// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes a word stream into a tile ccff chain behind an 8-bit preamble,
// then checks that the preamble comes back intact at ccff_tail.
module ccff_chain_loader #(
  parameter int         CHAIN_LEN = 20,
  parameter int         WORD_W    = 8,
  parameter logic [7:0] PREAMBLE  = 8'hA5
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              config_enable,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              pass
);
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int TOTAL     = 8 + CHAIN_LEN;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int CW        = $clog2(TOTAL + 1);
  localparam int WCW       = $clog2(NWORDS + 1);
  localparam int IW        = WORD_W > 1 ? $clog2(WORD_W) : 1;
  localparam logic [CW-1:0]  C_TOTAL    = CW'(TOTAL);
  localparam logic [CW-1:0]  C_CHAIN    = CW'(CHAIN_LEN);
  localparam logic [CW-1:0]  C_PRE      = CW'(8);
  localparam logic [WCW-1:0] C_NW       = WCW'(NWORDS);
  localparam logic [WCW-1:0] C_NW1      = WCW'(NWORDS - 1);
  localparam logic [IW-1:0]  C_FULL_END = IW'(WORD_W - 1);
  localparam logic [IW-1:0]  C_LAST_END = IW'(LAST_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_PAY, S_FIN, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [WCW-1:0]    r_words;
  logic [WORD_W-1:0] r_buf;
  logic              r_full;
  logic [IW-1:0]     r_idx;
  logic [7:0]        r_cap;
  logic              r_cen;
  logic              r_head;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic              w_acc;
  logic [CW-1:0]     w_cnt_n;
  logic [WORD_W-1:0] w_word;
  logic [IW-1:0]     w_idx;
  logic              w_lastw;
  logic              w_end;
  logic              w_pbit;
  logic              w_prebit;
  logic              w_run;
  logic              w_have;
  logic              w_take;

  assign bs_ready      = r_busy && !r_full && (r_words < C_NW);
  assign config_enable = r_cen;
  assign ccff_head     = r_head;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;

  // A word arriving while the buffer is empty is bypassed straight to the head so that
  // the last shift of one word and the acceptance of the next share an edge.
  assign w_acc    = bs_valid && bs_ready;
  assign w_cnt_n  = r_cnt + {{(CW-1){1'b0}}, r_cen};
  assign w_word   = r_full ? r_buf : bs_data;
  assign w_idx    = r_full ? r_idx : '0;
  assign w_lastw  = r_full ? (r_words == C_NW) : (r_words == C_NW1);
  assign w_end    = w_idx == (w_lastw ? C_LAST_END : C_FULL_END);
  assign w_pbit   = w_word[C_FULL_END - w_idx];
  assign w_prebit = PREAMBLE[3'd7 - w_cnt_n[2:0]];
  assign w_run    = (r_state == S_PRE) || (r_state == S_PAY);
  assign w_have   = r_full || w_acc;
  assign w_take   = w_run && (w_cnt_n >= C_PRE) && (w_cnt_n != C_TOTAL) && w_have;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_words <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
      r_idx   <= '0;
      r_cap   <= '0;
      r_cen   <= 1'b0;
      r_head  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      if (w_acc) r_words <= r_words + WCW'(1);
      if (w_take) begin
        r_buf  <= w_word;
        r_full <= !w_end;
        r_idx  <= w_end ? '0 : w_idx + IW'(1);
      end else if (w_acc) begin
        r_buf  <= bs_data;
        r_full <= 1'b1;
        r_idx  <= '0;
      end
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_state <= S_PRE;
          r_cen   <= 1'b1;
          r_head  <= PREAMBLE[7];
          r_cnt   <= '0;
          r_words <= '0;
          r_full  <= 1'b0;
          r_idx   <= '0;
          r_cap   <= '0;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
        S_PRE, S_PAY: begin
          r_cnt <= w_cnt_n;
          if (r_cen && (w_cnt_n > C_CHAIN)) r_cap <= {r_cap[6:0], ccff_tail};
          if (w_cnt_n == C_TOTAL) begin
            r_cen   <= 1'b0;
            r_state <= S_FIN;
          end else if (w_cnt_n < C_PRE) begin
            r_cen  <= 1'b1;
            r_head <= w_prebit;
          end else begin
            r_state <= S_PAY;
            r_cen   <= w_have;
            if (w_have) r_head <= w_pbit;
          end
        end
        S_FIN: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= r_cap == PREAMBLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain writer for a fabric tile's ccff_head/ccff_tail scan chain. Accepts the bitstream as parallel words over a valid/ready stream and serializes it into a tile's chain of CHAIN_LEN configuration flops. It first shifts a fixed 8-bit preamble so that the preamble emerges at ccff_tail during the final 8 shifts. That returned preamble checks chain continuity and length. The block sits between the bitstream source (test controller or SPI bridge) and the head of one tile chain, with ccff_tail looped back to it.

## Interface
- CHAIN_LEN, 20: configuration flops in the driven chain, ≥1.
- WORD_W, 8: bitstream word width, ≥1.
- PREAMBLE, 8'hA5: check pattern, shifted MSB first.
- prog_clk  in  1  programming clock; all state on rising edge.
- pReset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- bs_data  in  WORD_W  bitstream word; MSB is shifted first.
- bs_valid  in  1  bs_data valid.
- bs_ready  out  1  word accepted on edge where bs_valid && bs_ready.
- config_enable  out  1  registered; chain shifts on every prog_clk edge where it is 1.
- ccff_head  out  1  registered serial data into chain head.
- ccff_tail  in  1  serial data from chain tail.
- busy  out  1  load in progress.
- done  out  1  load finished; held until next start.
- pass  out  1  preamble returned intact; valid while done=1, else 0.

## Operation
- A shift edge is a prog_clk rising edge with config_enable=1. The controller counts shifts and samples ccff_tail only on shift edges.
- Total shifts per load: 8 + CHAIN_LEN.
  - Shifts 1..8 carry PREAMBLE[7]..PREAMBLE[0].
  - Shifts 9..8+CHAIN_LEN carry payload bits in stream order.
- NWORDS = ceil(CHAIN_LEN/WORD_W).
  - Payload bits are taken MSB first from words 0..NWORDS-1.
  - The unused low-order bits of the last word are discarded.
  - The first payload bit ends in the tail-most flop.
- One-word buffer plus bit index.
  - bs_ready = busy && buffer empty && words accepted < NWORDS.
  - Prefetch is allowed during the preamble.
- FSM:
  - IDLE: start=1 goes to PRE. On that edge config_enable←1 and ccff_head←PREAMBLE[7].
  - PRE: drives the preamble bits. After the shift edge of bit 8 it goes to PAY. If no payload bit is ready, config_enable←0.
  - PAY: a new bit is presented only when one is available. If the buffer is empty when the next bit is needed, config_enable←0 (stall). The chain holds its contents, and shifting resumes the cycle after a word is accepted. After shift 8+CHAIN_LEN, config_enable←0 and the FSM goes to DONE.
  - DONE: done=1, busy=0. start=1 goes to PRE (a new load) and clears done/pass on that edge.
- Tail check: on shift edges CHAIN_LEN+1..CHAIN_LEN+8, the sampled ccff_tail is shifted into an 8-bit capture register, MSB first. On entering DONE, pass←(capture == PREAMBLE).
- start is ignored while busy. bs_valid outside bs_ready windows is ignored, and no data is consumed.
- Counters are sized for 8+CHAIN_LEN and NWORDS. No wrap-around within a load.

## Timing
- Reset values: bs_ready=0, config_enable=0, ccff_head=0, busy=0, done=0, pass=0. FSM=IDLE, buffer empty, counters 0.
- Reset asserted mid-load:
  - All outputs return to reset values immediately (asynchronous).
  - Chain contents are undefined, and no done is issued.
  - After release, the FSM waits in IDLE for start.
- start edge → config_enable=1 in the next cycle. First shift occurs 1 cycle after start.
- With bs_valid held high, a load takes exactly 8+CHAIN_LEN shift cycles with no stall. done rises on the edge after the last shift, i.e. start-to-done = 9+CHAIN_LEN cycles.
- Each stall cycle adds exactly 1 cycle, with config_enable=0 and ccff_head held.
- A word is accepted in the same edge as the last shift of the previous word. Prefetch allows back-to-back shifting with no bubble.

## Test plan
- Nominal load: CHAIN_LEN=20, WORD_W=8, ideal 20-flop shift-register model, bs_valid always 1, words 8'hC3, 8'h5A, 8'hF0.
  - Requires 28 shift edges and done at start+29.
  - Model contents must equal bits C3,5A,F (first bit at the tail).
  - pass=1, and exactly 3 words accepted.
- Stall: deassert bs_valid for 5 cycles before word 1.
  - config_enable must be 0 for exactly those cycles, with the model unchanged.
  - done at start+34, pass=1.
- Broken chain: model tail stuck at 0.
  - Requires done=1, pass=0.
- Wrong length: model with 19 flops.
  - Capture reads A5 shifted by one bit (8'h4B); requires pass=0.
- Reset mid-load: assert pReset low after shift 12.
  - All outputs 0 asynchronously.
  - A new start after release completes normally with pass=1.
- Restart from DONE and start-while-busy:
  - start pulses during PAY are ignored.
  - start in DONE clears done/pass on that edge and repeats the nominal result.
